// File: rtl/am_prototype_trainer.sv
// am_prototype_trainer: majority-fuses labelled training samples, accumulates them into saturating per-bit counters and thresholds each batch into a class prototype
//   Clk_CI, Reset_RI                  clock, synchronous active-high reset
//   ValidIn_SI / ReadyOut_SO          training sample handshake
//   HypervectorIn_mod{1,2,3}_DI       modality hypervectors of the sample
//   LabelIn_DI, LastIn_SI             sample label, sample closes the batch
//   ValidOut_SO / ReadyIn_SI          prototype handshake
//   PrototypeOut_DO, LabelOut_DO      thresholded prototype and its label
//   SampleCountOut_DO                 samples fused into the prototype
//   LabelError_SO                     sticky: a sample was dropped on label mismatch
module am_prototype_trainer #(
    parameter int HV_DIMENSION = 1024,
    parameter int CHUNK        = 128,
    parameter int CNT_WIDTH    = 8,
    parameter int LABEL_WIDTH  = 1
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [HV_DIMENSION-1:0] HypervectorIn_mod1_DI,
    input  logic [HV_DIMENSION-1:0] HypervectorIn_mod2_DI,
    input  logic [HV_DIMENSION-1:0] HypervectorIn_mod3_DI,
    input  logic [LABEL_WIDTH-1:0]  LabelIn_DI,
    input  logic                    LastIn_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [HV_DIMENSION-1:0] PrototypeOut_DO,
    output logic [LABEL_WIDTH-1:0]  LabelOut_DO,
    output logic [CNT_WIDTH-1:0]    SampleCountOut_DO,
    output logic                    LabelError_SO
);
    localparam int NUM_CHUNKS = HV_DIMENSION / CHUNK;
    localparam int CIW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
    localparam logic signed [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
    localparam logic signed [CNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;
    localparam logic signed [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] SAMPLE_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, THRESHOLD, OUTPUT_STABLE} state_t;
    state_t State_SP, State_SN;

    logic [HV_DIMENSION-1:0]     Query_DP;
    logic [LABEL_WIDTH-1:0]      BatchLabel_DP;
    logic                        Last_SP, Drop_SP, BatchOpen_SP;
    logic [CIW-1:0]              Chunk_DP;
    logic [CNT_WIDTH-1:0]        SampleCount_DP;
    logic signed [CNT_WIDTH-1:0] Counter_DP [HV_DIMENSION];

    logic                    accept, mismatch;
    logic [HV_DIMENSION-1:0] fused;

    assign accept   = State_SP == IDLE && ValidIn_SI;
    assign mismatch = BatchOpen_SP && LabelIn_DI != BatchLabel_DP;
    assign fused    = (HypervectorIn_mod1_DI & HypervectorIn_mod2_DI) |
                      (HypervectorIn_mod1_DI & HypervectorIn_mod3_DI) |
                      (HypervectorIn_mod2_DI & HypervectorIn_mod3_DI);
    assign ReadyOut_SO = State_SP == IDLE;
    assign ValidOut_SO = State_SP == OUTPUT_STABLE;

    function automatic logic signed [CNT_WIDTH-1:0] stepCounter(input logic signed [CNT_WIDTH-1:0] c, input logic up);
        return up ? (c == CNT_MAX ? c : c + CNT_ONE) : (c == CNT_MIN ? c : c - CNT_ONE);
    endfunction

    always_comb begin
        State_SN = State_SP;
        case (State_SP)
            IDLE:          State_SN = ValidIn_SI ? ACCUM : IDLE;
            ACCUM:         State_SN = Chunk_DP != CIW'(NUM_CHUNKS-1) ? ACCUM : Last_SP ? THRESHOLD : IDLE;
            THRESHOLD:     State_SN = OUTPUT_STABLE;
            OUTPUT_STABLE: State_SN = ReadyIn_SI ? IDLE : OUTPUT_STABLE;
            default:       State_SN = IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            State_SP          <= IDLE;
            Query_DP          <= '0;
            BatchLabel_DP     <= '0;
            Last_SP           <= 1'b0;
            Drop_SP           <= 1'b0;
            BatchOpen_SP      <= 1'b0;
            Chunk_DP          <= '0;
            SampleCount_DP    <= '0;
            LabelOut_DO       <= '0;
            SampleCountOut_DO <= '0;
            LabelError_SO     <= 1'b0;
        end else begin
            State_SP <= State_SN;
            if (accept) begin
                Query_DP <= fused;
                Last_SP  <= LastIn_SI;
                Drop_SP  <= mismatch;
                Chunk_DP <= '0;
                if (mismatch) begin
                    LabelError_SO <= 1'b1;
                end else begin
                    BatchOpen_SP   <= 1'b1;
                    BatchLabel_DP  <= LabelIn_DI;
                    SampleCount_DP <= SampleCount_DP == SAMPLE_MAX ? SAMPLE_MAX : SampleCount_DP + CNT_WIDTH'(1);
                end
            end
            if (State_SP == ACCUM)
                Chunk_DP <= Chunk_DP + CIW'(1);
            if (State_SP == THRESHOLD) begin
                LabelOut_DO       <= BatchLabel_DP;
                SampleCountOut_DO <= SampleCount_DP;
                SampleCount_DP    <= '0;
                BatchOpen_SP      <= 1'b0;
            end
            if (State_SP == OUTPUT_STABLE && ReadyIn_SI)
                LabelError_SO <= 1'b0;
        end
    end

    // A zero counter is a tie and falls back to the final sample's fused bit.
    always_ff @(posedge Clk_CI) begin
        for (int k = 0; k < HV_DIMENSION; k++) begin
            if (Reset_RI) begin
                Counter_DP[k]      <= '0;
                PrototypeOut_DO[k] <= 1'b0;
            end else if (State_SP == ACCUM && !Drop_SP && Chunk_DP == CIW'(k / CHUNK)) begin
                Counter_DP[k] <= stepCounter(Counter_DP[k], Query_DP[k]);
            end else if (State_SP == THRESHOLD) begin
                PrototypeOut_DO[k] <= Counter_DP[k] == '0 ? Query_DP[k] : ~Counter_DP[k][CNT_WIDTH-1];
                Counter_DP[k]      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_am_prototype_trainer.sv
// tb_am_prototype_trainer: directed self-checking bench for am_prototype_trainer
module tb_am_prototype_trainer;
    localparam int HV = 1024;
    localparam int LW = 1;
    localparam int CW = 8;

    logic          Clk_CI = 1'b0;
    logic          Reset_RI = 1'b1;
    logic          ValidIn_SI = 1'b0;
    logic          ReadyOut_SO;
    logic [HV-1:0] Mod1_D = '0, Mod2_D = '0, Mod3_D = '0;
    logic [LW-1:0] LabelIn_DI = '0;
    logic          LastIn_SI = 1'b0;
    logic          ValidOut_SO;
    logic          ReadyIn_SI = 1'b0;
    logic [HV-1:0] PrototypeOut_DO;
    logic [LW-1:0] LabelOut_DO;
    logic [CW-1:0] SampleCountOut_DO;
    logic          LabelError_SO;

    int passed = 0, failed = 0, total = 0;
    logic [HV-1:0] A, B, C, H;

    am_prototype_trainer #(.HV_DIMENSION(HV), .CHUNK(128), .CNT_WIDTH(CW), .LABEL_WIDTH(LW)) dut (
        .Clk_CI(Clk_CI), .Reset_RI(Reset_RI),
        .ValidIn_SI(ValidIn_SI), .ReadyOut_SO(ReadyOut_SO),
        .HypervectorIn_mod1_DI(Mod1_D), .HypervectorIn_mod2_DI(Mod2_D), .HypervectorIn_mod3_DI(Mod3_D),
        .LabelIn_DI(LabelIn_DI), .LastIn_SI(LastIn_SI),
        .ValidOut_SO(ValidOut_SO), .ReadyIn_SI(ReadyIn_SI),
        .PrototypeOut_DO(PrototypeOut_DO), .LabelOut_DO(LabelOut_DO),
        .SampleCountOut_DO(SampleCountOut_DO), .LabelError_SO(LabelError_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    task automatic check(input string tag, input logic [HV-1:0] got, input logic [HV-1:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got[63:0]=%h want[63:0]=%h (%0d bits differ)", tag, got[63:0], exp[63:0], $countones(got ^ exp));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk_CI);
            #1;
        end
    endtask

    task automatic send(input logic [HV-1:0] a, input logic [HV-1:0] b, input logic [HV-1:0] c,
                        input logic [LW-1:0] l, input logic last);
        int n = 0;
        while (!ReadyOut_SO && n < 100) begin
            tick(1);
            n++;
        end
        if (n == 100) check("ready_timeout", HV'(ReadyOut_SO), HV'(1));
        Mod1_D = a; Mod2_D = b; Mod3_D = c;
        LabelIn_DI = l; LastIn_SI = last; ValidIn_SI = 1'b1;
        tick(1);
        ValidIn_SI = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        while (!ValidOut_SO && lat < 100) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic expectOut(input string tag, input logic [HV-1:0] p, input logic [LW-1:0] l,
                             input logic [CW-1:0] c, input logic e);
        check({tag, "_valid"}, HV'(ValidOut_SO), HV'(1));
        check({tag, "_ready"}, HV'(ReadyOut_SO), HV'(0));
        check({tag, "_proto"}, PrototypeOut_DO, p);
        check({tag, "_label"}, HV'(LabelOut_DO), HV'(l));
        check({tag, "_count"}, HV'(SampleCountOut_DO), HV'(c));
        check({tag, "_err"}, HV'(LabelError_SO), HV'(e));
    endtask

    task automatic handshake();
        ReadyIn_SI = 1'b1;
        tick(1);
        ReadyIn_SI = 1'b0;
    endtask

    initial begin
        int lat;
        logic sawValid;
        for (int i = 0; i < HV / 32; i++) begin
            A[i*32 +: 32] = $urandom();
            B[i*32 +: 32] = A[i*32 +: 32] ^ $urandom();
            C[i*32 +: 32] = $urandom();
            H[i*32 +: 32] = $urandom();
        end

        tick(2);
        Reset_RI = 1'b0;
        check("rst_ready", HV'(ReadyOut_SO), HV'(1));
        check("rst_valid", HV'(ValidOut_SO), HV'(0));
        check("rst_proto", PrototypeOut_DO, '0);
        check("rst_label", HV'(LabelOut_DO), HV'(0));
        check("rst_count", HV'(SampleCountOut_DO), HV'(0));
        check("rst_err", HV'(LabelError_SO), HV'(0));

        send(H, H, H, 1, 1);
        check("busy_ready", HV'(ReadyOut_SO), HV'(0));
        waitValid(lat);
        check("latency", HV'(lat), HV'(10));
        expectOut("single", H, 1, 1, 0);
        handshake();
        check("post_hs_valid", HV'(ValidOut_SO), HV'(0));
        check("post_hs_ready", HV'(ReadyOut_SO), HV'(1));

        send(H, H, ~H, 0, 1);
        waitValid(lat);
        expectOut("majority", H, 0, 1, 0);
        handshake();

        send(A, A, A, 0, 0);
        send(A, A, A, 0, 0);
        send(B, B, B, 0, 1);
        waitValid(lat);
        expectOut("batch", A, 0, 3, 0);
        handshake();

        send(A, A, A, 0, 0);
        send(~A, ~A, ~A, 0, 1);
        waitValid(lat);
        expectOut("tie", ~A, 0, 2, 0);
        handshake();

        for (int i = 0; i < 200; i++) send(A, A, A, 0, 0);
        for (int i = 0; i < 126; i++) send(~A, ~A, ~A, 0, 0);
        send(~A, ~A, ~A, 0, 1);
        waitValid(lat);
        expectOut("saturate", ~A, 0, 255, 0);
        handshake();

        send(A, A, A, 0, 0);
        send(B, B, B, 1, 1);
        waitValid(lat);
        expectOut("mismatch", A, 0, 1, 1);
        tick(5);
        expectOut("hold", A, 0, 1, 1);
        handshake();
        check("err_cleared", HV'(LabelError_SO), HV'(0));

        send(H, H, H, 1, 1);
        tick(3);
        Reset_RI = 1'b1;
        tick(1);
        Reset_RI = 1'b0;
        check("abort_ready", HV'(ReadyOut_SO), HV'(1));
        sawValid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            sawValid |= ValidOut_SO;
            tick(1);
        end
        check("abort_no_valid", HV'(sawValid), HV'(0));
        send(C, C, C, 1, 1);
        waitValid(lat);
        check("after_rst_latency", HV'(lat), HV'(10));
        expectOut("after_rst", C, 1, 1, 0);
        handshake();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
